// File: rtl/lookahead_mp_sequencer.sv
// Multi-precision add/subtract sequencer: one B_W-bit carry-lookahead slice
// processes N_WORDS words LSW-first, carry chained through a register.
module lookahead_mp_sequencer #(
  parameter int unsigned B_W     = 4,
  parameter int unsigned N_WORDS = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   op_sub,
  input  logic [N_WORDS*B_W-1:0] a,
  input  logic [N_WORDS*B_W-1:0] b,
  output logic                   busy,
  output logic                   done,
  output logic [N_WORDS*B_W-1:0] result,
  output logic                   co,
  output logic                   v
);

  localparam int unsigned W  = N_WORDS * B_W;
  localparam int unsigned IW = $clog2(N_WORDS) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state, state_n;
  logic [W-1:0]   a_q, b_q;
  logic           carry;
  logic [IW-1:0]  idx;
  logic [B_W-1:0] wa, wb, s;
  logic [B_W:0]   c;
  logic           last;
  logic           accept;

  assign accept = start && (state == IDLE || state == DONE);
  assign last   = (idx == IW'(N_WORDS - 1));
  assign busy   = (state == RUN);
  assign done   = (state == DONE);

  assign wa = a_q[idx*B_W +: B_W];
  assign wb = b_q[idx*B_W +: B_W];

  // Carry-lookahead slice: G=a&b, P=a|b, C[i+1]=G|P&C[i]
  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = carry;
    for (int unsigned i = 0; i < B_W; i++) begin
      c[i+1] = (wa[i] & wb[i]) | ((wa[i] | wb[i]) & c[i]);
      s[i]   = wa[i] ^ wb[i] ^ c[i];
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start) state_n = RUN;
      RUN:     if (last)  state_n = DONE;
      DONE:    state_n = start ? RUN : IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q    <= '0;
      b_q    <= '0;
      carry  <= 1'b0;
      idx    <= '0;
      result <= '0;
      co     <= 1'b0;
      v      <= 1'b0;
    end else if (accept) begin
      // Subtraction is A + ~B + 1: B inverted here, the +1 enters as initial carry
      a_q    <= a;
      b_q    <= b ^ {W{op_sub}};
      carry  <= op_sub;
      idx    <= '0;
      result <= '0;
    end else if (state == RUN) begin
      result[idx*B_W +: B_W] <= s;
      carry <= c[B_W];
      idx   <= last ? '0 : idx + IW'(1);
      if (last) begin
        co <= c[B_W];
        v  <= (a_q[W-1] == b_q[W-1]) & (s[B_W-1] != a_q[W-1]);
      end
    end
  end

endmodule

// File: tb/tb_lookahead_mp_sequencer.sv
// Directed self-checking bench for lookahead_mp_sequencer (4x4-bit and 1x4-bit instances).
module tb_lookahead_mp_sequencer;

  logic        clk = 1'b0;
  logic        rst, start, op_sub;
  logic [15:0] a, b, result;
  logic        busy, done, co, v;

  logic        start1, op_sub1;
  logic [3:0]  a1, b1, result1;
  logic        busy1, done1, co1, v1;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  lookahead_mp_sequencer #(.B_W(4), .N_WORDS(4)) dut (
    .clk(clk), .rst(rst), .start(start), .op_sub(op_sub), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .co(co), .v(v)
  );

  lookahead_mp_sequencer #(.B_W(4), .N_WORDS(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .op_sub(op_sub1), .a(a1), .b(b1),
    .busy(busy1), .done(done1), .result(result1), .co(co1), .v(v1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called 1 time unit after a rising edge; returns in the done cycle.
  task automatic run_op(input string tag, input logic sub, input logic [15:0] aa, input logic [15:0] bb,
                        input logic [15:0] er, input logic eco, input logic ev);
    start = 1'b1; op_sub = sub; a = aa; b = bb;
    tick();
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check({tag, "_busy"}, 32'(busy), 32'd1);
      check({tag, "_early_done"}, 32'(done), 32'd0);
      tick();
    end
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_busy_off"}, 32'(busy), 32'd0);
    check({tag, "_result"}, 32'(result), 32'(er));
    check({tag, "_co"}, 32'(co), 32'(eco));
    check({tag, "_v"}, 32'(v), 32'(ev));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; start = 1'b0; op_sub = 1'b0; a = '0; b = '0;
    start1 = 1'b0; op_sub1 = 1'b0; a1 = '0; b1 = '0;
    tick(); tick();
    rst = 1'b0;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_co", 32'(co), 32'd0);
    check("rst_v", 32'(v), 32'd0);
    tick();

    run_op("add_carry_chain", 1'b0, 16'h00FF, 16'h0001, 16'h0100, 1'b0, 1'b0);
    tick();
    check("done_pulse", 32'(done), 32'd0);
    check("result_hold", 32'(result), 32'h0100);

    run_op("add_ovf", 1'b0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1);
    tick();
    run_op("add_wrap", 1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0);
    tick();
    run_op("sub_borrow", 1'b1, 16'h0000, 16'h0001, 16'hFFFF, 1'b0, 1'b0);
    tick();

    // sub 0x8000-1 with a start pulse (other operands) in RUN that must be ignored
    start = 1'b1; op_sub = 1'b1; a = 16'h8000; b = 16'h0001;
    tick();
    start = 1'b0;
    tick();
    start = 1'b1; op_sub = 1'b0; a = 16'h1234; b = 16'h1111;
    tick();
    start = 1'b0;
    tick(); tick();
    check("ign_done", 32'(done), 32'd1);
    check("ign_result", 32'(result), 32'h7FFF);
    check("ign_co", 32'(co), 32'd1);
    check("ign_v", 32'(v), 32'd1);
    tick();

    // add 0x1234+0x1111 with ignored start at T+2
    start = 1'b1; op_sub = 1'b0; a = 16'h1234; b = 16'h1111;
    tick();
    start = 1'b0;
    tick();
    start = 1'b1; op_sub = 1'b1; a = 16'hAAAA; b = 16'h5555;
    tick();
    start = 1'b0;
    tick(); tick();
    check("ign2_done", 32'(done), 32'd1);
    check("ign2_result", 32'(result), 32'h2345);
    check("ign2_v", 32'(v), 32'd0);
    tick();

    // Abort: reset in cycle T+3 discards the partial result
    start = 1'b1; op_sub = 1'b0; a = 16'h1234; b = 16'h1111;
    tick();
    start = 1'b0;
    tick(); tick();
    check("abort_partial", 32'(result), 32'h0045);
    check("abort_busy_pre", 32'(busy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_result", 32'(result), 32'd0);
    check("abort_co", 32'(co), 32'd0);
    check("abort_v", 32'(v), 32'd0);
    for (int k = 0; k < 5; k++) begin
      check("abort_no_done", 32'(done), 32'd0);
      tick();
    end

    // Back-to-back: second start issued in the done cycle of the first
    run_op("b2b_first", 1'b0, 16'h00FF, 16'h0001, 16'h0100, 1'b0, 1'b0);
    start = 1'b1; op_sub = 1'b1; a = 16'h8000; b = 16'h0001;
    tick();
    start = 1'b0;
    check("b2b_cleared", 32'(result), 32'd0);
    check("b2b_busy", 32'(busy), 32'd1);
    tick(); tick(); tick();
    check("b2b_not_yet", 32'(done), 32'd0);
    tick();
    check("b2b_done", 32'(done), 32'd1);
    check("b2b_result", 32'(result), 32'h7FFF);
    check("b2b_co", 32'(co), 32'd1);
    check("b2b_v", 32'(v), 32'd1);
    tick();

    // Single-word instance: done at T+2
    start1 = 1'b1; op_sub1 = 1'b0; a1 = 4'hF; b1 = 4'h1;
    tick();
    start1 = 1'b0;
    check("w1_busy", 32'(busy1), 32'd1);
    tick();
    check("w1_done", 32'(done1), 32'd1);
    check("w1_result", 32'(result1), 32'h0);
    check("w1_co", 32'(co1), 32'd1);
    check("w1_v", 32'(v1), 32'd0);
    start1 = 1'b1; op_sub1 = 1'b0; a1 = 4'h7; b1 = 4'h1;
    tick();
    start1 = 1'b0;
    tick();
    check("w1b_done", 32'(done1), 32'd1);
    check("w1b_result", 32'(result1), 32'h8);
    check("w1b_co", 32'(co1), 32'd0);
    check("w1b_v", 32'(v1), 32'd1);
    tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
